mouse_motion_encoder: RTL
=========================

// Module: mouse_motion_encoder
// PURPOSE
//  Producer side of the object velocity interface: turns raw PS/2 mouse deltas into
//  {vx, vy, dx, dy} magnitude/direction pairs consumed by object movers, once per
//  moveclk period. Also tracks an on-screen cursor, clamped to the screen.
//  Sits between the PS/2 mouse packet receiver and the blade/object motion logic.
// PARAMETERS
//  SCREEN_W   640   cursor X range 0..SCREEN_W-1
//  SCREEN_H   480   cursor Y range 0..SCREEN_H-1
//  INIT_X     320   cursor X after reset
//  INIT_Y     240   cursor Y after reset
//  VEL_SHIFT  0     published magnitude = |accumulated delta| >> VEL_SHIFT
// PORTS
//  clk         in   1   system clock
//  rstn        in   1   synchronous active-low reset
//  mouseReady  in   1   1-cycle strobe: new packet deltas valid
//  mdx         in   9   X delta, two's complement, +right
//  mdy         in   9   Y delta, two's complement, +up (PS/2 convention)
//  xovf        in   1   X overflow flag of packet
//  yovf        in   1   Y overflow flag of packet
//  moveclk     in   1   slow movement clock (level, asynchronous to clk)
//  vx          out  10  X speed magnitude
//  vy          out  9   Y speed magnitude
//  dx          out  1   0 = +X (right), 1 = -X
//  dy          out  1   0 = +Y (screen down), 1 = -Y (screen up)
//  velValid    out  1   1-cycle pulse when vx/vy/dx/dy update
//  cursorX     out  10  clamped cursor X
//  cursorY     out  9   clamped cursor Y (screen coords, down positive)
// BEHAVIOUR
//  - Reset (rstn=0 at clk edge): vx=0, vy=0, dx=0, dy=0, velValid=0,
//    cursorX=INIT_X, cursorY=INIT_Y, accumulators=0, sync regs=0.
//  - moveclk: 2-FF synchroniser + rising-edge detect -> tick (1 clk wide), latency 3 clk
//    from moveclk rise. Falling edges ignored.
//  - Delta conditioning: ovf=1 -> delta forced to +255 / -256 by sign bit. Y is negated
//    on entry (screen Y = -mdy) before accumulation and cursor update.
//  - Accumulators: accX signed 12b, accY signed 11b; on mouseReady add conditioned delta,
//    saturating at type limits (no wrap).
//  - On tick: publish from accumulator value including any same-cycle mouseReady delta;
//    mag = |acc| >> VEL_SHIFT, saturate to 1023 (vx) / 511 (vy); dx/dy = sign of acc;
//    acc == 0 -> magnitude 0, direction 0. Accumulators cleared the same cycle.
//    Outputs registered: visible, with velValid=1, the cycle after tick. Held until next tick.
//  - Simultaneous mouseReady and tick: delta counted in the period being published;
//    never lost, never double-counted.
//  - Cursor: on mouseReady, cursor += conditioned delta, computed signed, clamped to
//    [0, SCREEN_W-1] / [0, SCREEN_H-1]; result visible next cycle.
//  - Reset mid-period discards accumulated motion; the first tick after reset publishes
//    only deltas received after reset.
//  - Reset to velValid=1: velValid=0 next cycle (reset wins).
// STRUCTURE
//  - Shared package mouse_pkg: SCREEN_W/SCREEN_H defaults, VX_MAX=1023, VY_MAX=511,
//    delta width 9.
//  - Sub-module moveclk_tick: synchroniser + rising-edge pulse generator, reused by other
//    movers. The remainder (conditioning, accumulators, publish, cursor clamp) stays inline.
// TESTING
//  1. Reset, 3x mouseReady mdx=+10, then moveclk rise -> vx=30, dx=0, velValid 1 pulse,
//     cursorX=350.
//  2. mdy=+20 (up), tick -> vy=20, dy=1, cursorY=220; mdx=-5 then tick -> vx=5, dx=1.
//  3. xovf=1, mdx sign=1, 8 packets, tick -> vx=1023 saturated, dx=1, cursorX=0 clamped.
//  4. mouseReady mdx=+7 in same cycle as tick, after prior +3 -> vx=10; next tick with no
//     packets -> vx=0, dx=0.
//  5. Accumulate +50, assert rstn=0 for 1 clk mid-period, tick -> vx=0; cursor=INIT.
//  6. Cursor at X=630, mdx=+100 -> cursorX=639; VEL_SHIFT=2, acc=+13 -> vx=3.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared constants and delta conditioning for the mouse-driven velocity producers.
package mouse_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int VX_MAX       = 1023;
  localparam int VY_MAX       = 511;
  localparam int DELTA_W      = 9;
  localparam int ACC_X_W      = 12;
  localparam int ACC_Y_W      = 11;

  // Conditioned delta carries one extra bit so that a negated -256 (+256) still fits.
  typedef logic signed [DELTA_W:0] cdelta_t;

  // Overflowed packets are pinned to the extreme value of their sign; Y is negated
  // so that downstream logic sees screen coordinates (down positive).
  function automatic cdelta_t condition_delta(input logic [DELTA_W-1:0] d,
                                              input logic               ovf,
                                              input logic               negate);
    cdelta_t v;
    if (ovf) v = d[DELTA_W-1] ? -10'sd256 : 10'sd255;
    else     v = {d[DELTA_W-1], d};
    return negate ? -v : v;
  endfunction

endpackage

// File: rtl/mouse_motion_encoder_if.sv
// Packet-in / velocity-out bundle between the PS/2 receiver side and object movers.
interface mouse_motion_encoder_if;

  // mouseReady is a 1-cycle strobe qualifying mdx/mdy/xovf/yovf; there is no back-pressure.
  // velValid is a 1-cycle pulse; vx/vy/dx/dy hold their value until the next pulse.
  logic       mouseReady;
  logic [8:0] mdx;
  logic [8:0] mdy;
  logic       xovf;
  logic       yovf;
  logic       moveclk;
  logic [9:0] vx;
  logic [8:0] vy;
  logic       dx;
  logic       dy;
  logic       velValid;
  logic [9:0] cursorX;
  logic [8:0] cursorY;

  modport master (
    output mouseReady, mdx, mdy, xovf, yovf, moveclk,
    input  vx, vy, dx, dy, velValid, cursorX, cursorY
  );

  modport slave (
    input  mouseReady, mdx, mdy, xovf, yovf, moveclk,
    output vx, vy, dx, dy, velValid, cursorX, cursorY
  );

endinterface

// File: rtl/mouse_motion_encoder_tick.sv
// moveclk_tick: brings the slow movement clock into clk and emits one pulse per rising edge.
module moveclk_tick (
  input  logic clk,
  input  logic rstn,
  input  logic async_i,
  output logic tick_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic tick_q;

  // Registered pulse: three clk edges after the asynchronous rise, falling edges ignored.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= sync2_q & ~prev_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/mouse_motion_encoder.sv
// Accumulates PS/2 deltas per moveclk period, publishes speed/direction and tracks a clamped cursor.
module mouse_motion_encoder
  import mouse_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int INIT_X    = 320,
  parameter int INIT_Y    = 240,
  parameter int VEL_SHIFT = 0
) (
  input logic                    clk,
  input logic                    rstn,
  mouse_motion_encoder_if.slave  bus
);

  localparam logic signed [12:0] ACC_X_HI = 13'sd2047;
  localparam logic signed [12:0] ACC_X_LO = -13'sd2048;
  localparam logic signed [11:0] ACC_Y_HI = 12'sd1023;
  localparam logic signed [11:0] ACC_Y_LO = -12'sd1024;
  localparam logic signed [11:0] CUR_X_HI = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] CUR_Y_HI = 12'(SCREEN_H - 1);

  logic tick;

  moveclk_tick u_tick (
    .clk     (clk),
    .rstn    (rstn),
    .async_i (bus.moveclk),
    .tick_o  (tick)
  );

  cdelta_t cdx;
  cdelta_t cdy;
  assign cdx = condition_delta(bus.mdx, bus.xovf, 1'b0);
  assign cdy = condition_delta(bus.mdy, bus.yovf, 1'b1);

  logic signed [ACC_X_W-1:0] acc_x_q, acc_x_d, acc_x_upd, sat_x;
  logic signed [ACC_Y_W-1:0] acc_y_q, acc_y_d, acc_y_upd, sat_y;
  logic signed [ACC_X_W:0]   sum_x;
  logic signed [ACC_Y_W:0]   sum_y;
  logic [ACC_X_W-1:0]        abs_x, mag_x;
  logic [ACC_Y_W-1:0]        abs_y, mag_y;
  logic signed [11:0]        cur_x_sum, cur_y_sum;
  logic [9:0]                vx_q, vx_d, cursor_x_q, cursor_x_d;
  logic [8:0]                vy_q, vy_d, cursor_y_q, cursor_y_d;
  logic                      dx_q, dx_d, dy_q, dy_d, vel_valid_q, vel_valid_d;

  always_comb begin
    sum_x = {acc_x_q[ACC_X_W-1], acc_x_q} + {{3{cdx[9]}}, cdx};
    sum_y = {acc_y_q[ACC_Y_W-1], acc_y_q} + {{2{cdy[9]}}, cdy};

    if (sum_x > ACC_X_HI)      sat_x = ACC_X_HI[ACC_X_W-1:0];
    else if (sum_x < ACC_X_LO) sat_x = ACC_X_LO[ACC_X_W-1:0];
    else                       sat_x = sum_x[ACC_X_W-1:0];

    if (sum_y > ACC_Y_HI)      sat_y = ACC_Y_HI[ACC_Y_W-1:0];
    else if (sum_y < ACC_Y_LO) sat_y = ACC_Y_LO[ACC_Y_W-1:0];
    else                       sat_y = sum_y[ACC_Y_W-1:0];

    // A packet arriving on the tick cycle belongs to the period being published.
    acc_x_upd = bus.mouseReady ? sat_x : acc_x_q;
    acc_y_upd = bus.mouseReady ? sat_y : acc_y_q;

    abs_x = acc_x_upd[ACC_X_W-1] ? -acc_x_upd : acc_x_upd;
    abs_y = acc_y_upd[ACC_Y_W-1] ? -acc_y_upd : acc_y_upd;
    mag_x = abs_x >> VEL_SHIFT;
    mag_y = abs_y >> VEL_SHIFT;

    vx_d        = vx_q;
    vy_d        = vy_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    vel_valid_d = tick;
    acc_x_d     = acc_x_upd;
    acc_y_d     = acc_y_upd;
    if (tick) begin
      vx_d    = (mag_x > 12'(VX_MAX)) ? 10'(VX_MAX) : mag_x[9:0];
      vy_d    = (mag_y > 11'(VY_MAX)) ? 9'(VY_MAX)  : mag_y[8:0];
      dx_d    = acc_x_upd[ACC_X_W-1];
      dy_d    = acc_y_upd[ACC_Y_W-1];
      acc_x_d = '0;
      acc_y_d = '0;
    end

    cur_x_sum  = {2'b00, cursor_x_q} + {{2{cdx[9]}}, cdx};
    cur_y_sum  = {3'b000, cursor_y_q} + {{2{cdy[9]}}, cdy};
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    if (bus.mouseReady) begin
      if (cur_x_sum < 12'sd0)         cursor_x_d = '0;
      else if (cur_x_sum > CUR_X_HI)  cursor_x_d = CUR_X_HI[9:0];
      else                            cursor_x_d = cur_x_sum[9:0];
      if (cur_y_sum < 12'sd0)         cursor_y_d = '0;
      else if (cur_y_sum > CUR_Y_HI)  cursor_y_d = CUR_Y_HI[8:0];
      else                            cursor_y_d = cur_y_sum[8:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      vx_q        <= '0;
      vy_q        <= '0;
      dx_q        <= 1'b0;
      dy_q        <= 1'b0;
      vel_valid_q <= 1'b0;
      cursor_x_q  <= 10'(INIT_X);
      cursor_y_q  <= 9'(INIT_Y);
    end else begin
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      vel_valid_q <= vel_valid_d;
      cursor_x_q  <= cursor_x_d;
      cursor_y_q  <= cursor_y_d;
    end
  end

  assign bus.vx       = vx_q;
  assign bus.vy       = vy_q;
  assign bus.dx       = dx_q;
  assign bus.dy       = dy_q;
  assign bus.velValid = vel_valid_q;
  assign bus.cursorX  = cursor_x_q;
  assign bus.cursorY  = cursor_y_q;

endmodule
